// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port synchronous memory between an instruction
//            read port and a data read/write port with alternating priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int   ADDR_W  = 32,
    parameter int   DATA_W  = 32,
    parameter logic D_FIRST = 1'b1
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iIReadEnable,
    input  logic [ADDR_W-1:0]     iIAddress,
    output logic [DATA_W-1:0]     oIReadData,
    output logic                  oIReady,
    input  logic                  iDReadEnable,
    input  logic                  iDWriteEnable,
    input  logic [DATA_W/8-1:0]   iDByteEnable,
    input  logic [ADDR_W-1:0]     iDAddress,
    input  logic [DATA_W-1:0]     iDWriteData,
    output logic [DATA_W-1:0]     oDReadData,
    output logic                  oDReady,
    output logic                  oMReadEnable,
    output logic                  oMWriteEnable,
    output logic [DATA_W/8-1:0]   oMByteEnable,
    output logic [ADDR_W-1:0]     oMAddress,
    output logic [DATA_W-1:0]     oMWriteData,
    input  logic [DATA_W-1:0]     iMReadData
);

    localparam int               BE_W     = DATA_W / 8;
    localparam logic [BE_W-1:0]  BE_ALL   = '1;
    localparam logic [1:0]       ST_IDLE  = 2'd0;
    localparam logic [1:0]       ST_ISSUE = 2'd1;
    localparam logic [1:0]       ST_RESP  = 2'd2;
    localparam logic             OWN_I    = 1'b0;
    localparam logic             OWN_D    = 1'b1;

    logic [1:0]        state_q, state_d;
    // owner only changes on a grant, so it also serves as the previous owner
    logic              owner_q, owner_d;
    logic              hist_q, hist_d;
    logic              wr_q, wr_d;
    logic              m_re_q, m_re_d;
    logic              m_we_q, m_we_d;
    logic [BE_W-1:0]   m_be_q, m_be_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0] i_hold_q, i_hold_d;
    logic [DATA_W-1:0] d_hold_q, d_hold_d;
    logic              i_pend, d_pend, grant, winner;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_I;
            hist_q    <= 1'b0;
            wr_q      <= 1'b0;
            m_re_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_be_q    <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_hold_q  <= '0;
            d_hold_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            hist_q    <= hist_d;
            wr_q      <= wr_d;
            m_re_q    <= m_re_d;
            m_we_q    <= m_we_d;
            m_be_q    <= m_be_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_hold_q  <= i_hold_d;
            d_hold_q  <= d_hold_d;
        end
    end

    always_comb begin
        i_pend    = iIReadEnable;
        d_pend    = iDReadEnable | iDWriteEnable;
        grant     = 1'b0;
        winner    = OWN_I;
        state_d   = state_q;
        owner_d   = owner_q;
        hist_d    = hist_q;
        wr_d      = wr_q;
        m_re_d    = 1'b0;
        m_we_d    = 1'b0;
        m_be_d    = m_be_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_hold_d  = i_hold_q;
        d_hold_d  = d_hold_q;

        case (state_q)
            ST_IDLE: begin
                if (i_pend && d_pend) begin
                    grant  = 1'b1;
                    winner = hist_q ? ~owner_q : D_FIRST;
                end else if (d_pend || i_pend) begin
                    grant  = 1'b1;
                    winner = d_pend ? OWN_D : OWN_I;
                end
            end
            ST_ISSUE: state_d = ST_RESP;
            ST_RESP: begin
                // the owner's request is still asserted here; only the other side may be granted
                if (owner_q == OWN_D && i_pend) begin
                    grant  = 1'b1;
                    winner = OWN_I;
                end else if (owner_q == OWN_I && d_pend) begin
                    grant  = 1'b1;
                    winner = OWN_D;
                end
                if (!wr_q) begin
                    if (owner_q == OWN_D) d_hold_d = iMReadData;
                    else                  i_hold_d = iMReadData;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q != ST_ISSUE) state_d = grant ? ST_ISSUE : ST_IDLE;

        if (grant) begin
            owner_d = winner;
            hist_d  = 1'b1;
            if (winner == OWN_D) begin
                wr_d      = iDWriteEnable;
                m_we_d    = iDWriteEnable;
                m_re_d    = ~iDWriteEnable;
                m_be_d    = iDWriteEnable ? iDByteEnable : BE_ALL;
                m_addr_d  = iDAddress;
                m_wdata_d = iDWriteData;
            end else begin
                wr_d      = 1'b0;
                m_re_d    = 1'b1;
                m_be_d    = BE_ALL;
                m_addr_d  = iIAddress;
            end
        end
    end

    always_comb begin
        oIReady       = (state_q == ST_RESP) && (owner_q == OWN_I);
        oDReady       = (state_q == ST_RESP) && (owner_q == OWN_D);
        oIReadData    = (oIReady && !wr_q) ? iMReadData : i_hold_q;
        oDReadData    = (oDReady && !wr_q) ? iMReadData : d_hold_q;
        oMReadEnable  = m_re_q;
        oMWriteEnable = m_we_q;
        oMByteEnable  = m_be_q;
        oMAddress     = m_addr_q;
        oMWriteData   = m_wdata_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter (vectors, corner
//            sequences, randomized traffic against a transaction-level model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam logic D_FIRST_TB = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_re = 1'b0;
    logic [31:0] i_addr = '0;
    logic        d_re = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] m_rdata = '0;
    logic [31:0] o_i_rdata, o_d_rdata, o_m_addr, o_m_wdata;
    logic        o_i_rdy, o_d_rdy, o_m_re, o_m_we;
    logic [3:0]  o_m_be;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .D_FIRST(D_FIRST_TB)) dut (
        .iCLK(clk), .iRST(rst_n),
        .iIReadEnable(i_re), .iIAddress(i_addr), .oIReadData(o_i_rdata), .oIReady(o_i_rdy),
        .iDReadEnable(d_re), .iDWriteEnable(d_we), .iDByteEnable(d_be), .iDAddress(d_addr),
        .iDWriteData(d_wdata), .oDReadData(o_d_rdata), .oDReady(o_d_rdy),
        .oMReadEnable(o_m_re), .oMWriteEnable(o_m_we), .oMByteEnable(o_m_be),
        .oMAddress(o_m_addr), .oMWriteData(o_m_wdata), .iMReadData(m_rdata)
    );

    function automatic logic [31:0] init_word(input int k);
        if (k == 0)      return 32'h0000_0013;
        else if (k == 1) return 32'h1111_1111;
        else             return 32'hC0DE_0000 + k;
    endfunction

    // environment: synchronous memory, data one cycle after the address
    logic [31:0] mem [0:63];
    initial for (int k = 0; k < 64; k++) mem[k] = init_word(k);
    always @(posedge clk) begin
        if (o_m_we)
            for (int b = 0; b < 4; b++)
                if (o_m_be[b]) mem[o_m_addr[7:2]][8*b +: 8] = o_m_wdata[8*b +: 8];
        if (o_m_re) m_rdata <= mem[o_m_addr[7:2]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_re = 1'b0;
        d_re = 1'b0;
        d_we = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'h2000_0040 | (32'($urandom_range(0, 15)) << 2);
    endfunction

    typedef struct {
        logic        is_d, rd, wr;
        logic [31:0] addr, wdata;
        logic [3:0]  be;
        logic        exp_re, exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vt [8];

    // reference model state for the random phase
    logic [31:0] ref_mem [0:63];
    int          g_cyc;
    logic        have_txn, have_hist, last_d, g_d, g_wr, win_d, can_i, can_d;
    logic        exp_ir, exp_dr, i_seen, d_seen;
    logic [31:0] g_addr, g_wdata, g_rdata, hold_i, hold_d;
    logic [3:0]  g_be;
    int          n_rdy, prev_p, cur_p;
    int          last_seen [2];
    int          r;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //             is_d rd wr addr          wdata         be     re we ebe   rdata
        vt[0] = '{1'b0, 1'b1, 1'b0, 32'h0040_0000, 32'h0,        4'hF, 1'b1, 1'b0, 4'hF, 32'h0000_0013};
        vt[1] = '{1'b1, 1'b0, 1'b1, 32'h1001_0004, 32'hDEADBEEF, 4'h3, 1'b0, 1'b1, 4'h3, 32'h1111_1111};
        vt[2] = '{1'b1, 1'b1, 1'b0, 32'h1001_0004, 32'h0,        4'h5, 1'b1, 1'b0, 4'hF, 32'h1111_BEEF};
        vt[3] = '{1'b1, 1'b1, 1'b1, 32'h1001_0008, 32'h12345678, 4'hF, 1'b0, 1'b1, 4'hF, 32'h1111_BEEF};
        vt[4] = '{1'b0, 1'b1, 1'b0, 32'h1001_0008, 32'h0,        4'hF, 1'b1, 1'b0, 4'hF, 32'h1234_5678};
        vt[5] = '{1'b1, 1'b1, 1'b0, 32'h0040_0000, 32'h0,        4'hF, 1'b1, 1'b0, 4'hF, 32'h0000_0013};
        vt[6] = '{1'b1, 1'b0, 1'b1, 32'h1001_0008, 32'hAABBCCDD, 4'hC, 1'b0, 1'b1, 4'hC, 32'h0000_0013};
        vt[7] = '{1'b0, 1'b1, 1'b0, 32'h1001_0008, 32'h0,        4'hF, 1'b1, 1'b0, 4'hF, 32'hAABB_5678};

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("reset ordy", o_i_rdy, 0);
        check("reset drdy", o_d_rdy, 0);
        check("reset mre", o_m_re, 0);
        check("reset mwe", o_m_we, 0);
        check("reset mbe", o_m_be, 0);
        check("reset maddr", o_m_addr, 0);
        check("reset mwdata", o_m_wdata, 0);
        check("reset irdata", o_i_rdata, 0);
        check("reset drdata", o_d_rdata, 0);
        tick();
        rst_n = 1'b1;

        // simultaneous first requests: D wins the tie, I follows with no bubble
        tick();
        i_re = 1'b1; i_addr = 32'h0040_0000;
        d_re = 1'b1; d_addr = 32'h1001_0004;
        @(negedge clk);
        check("first c0 rdy", {o_i_rdy, o_d_rdy}, 0);
        tick(); @(negedge clk);
        check("first c1 mre", o_m_re, 1);
        check("first c1 addr", o_m_addr, 32'h1001_0004);
        tick(); @(negedge clk);
        check("first c2 drdy", o_d_rdy, 1);
        check("first c2 irdy", o_i_rdy, 0);
        check("first c2 ddata", o_d_rdata, 32'h1111_1111);
        tick(); d_re = 1'b0; @(negedge clk);
        check("first c3 mre", o_m_re, 1);
        check("first c3 addr", o_m_addr, 32'h0040_0000);
        tick(); @(negedge clk);
        check("first c4 irdy", o_i_rdy, 1);
        check("first c4 idata", o_i_rdata, 32'h0000_0013);
        tick(); i_re = 1'b0;

        // table-driven single transactions
        for (int v = 0; v < 8; v++) begin
            tick();
            i_re = !vt[v].is_d; i_addr = vt[v].addr;
            if (vt[v].is_d) begin
                d_re = vt[v].rd; d_we = vt[v].wr; d_addr = vt[v].addr;
                d_wdata = vt[v].wdata; d_be = vt[v].be;
            end
            @(negedge clk);
            tick(); @(negedge clk);
            check($sformatf("vec%0d mre", v), o_m_re, vt[v].exp_re);
            check($sformatf("vec%0d mwe", v), o_m_we, vt[v].exp_we);
            check($sformatf("vec%0d mbe", v), o_m_be, vt[v].exp_be);
            check($sformatf("vec%0d maddr", v), o_m_addr, vt[v].addr);
            if (vt[v].exp_we) check($sformatf("vec%0d mwdata", v), o_m_wdata, vt[v].wdata);
            tick(); @(negedge clk);
            check($sformatf("vec%0d rdy", v), vt[v].is_d ? {o_d_rdy, o_i_rdy} : {o_i_rdy, o_d_rdy}, 2'b10);
            check($sformatf("vec%0d rdata", v), vt[v].is_d ? o_d_rdata : o_i_rdata, vt[v].exp_rdata);
            check($sformatf("vec%0d strobes off", v), {o_m_re, o_m_we}, 0);
            tick(); idle_inputs(); @(negedge clk);
            check($sformatf("vec%0d hold", v), vt[v].is_d ? o_d_rdata : o_i_rdata, vt[v].exp_rdata);
            check($sformatf("vec%0d rdy low", v), {o_i_rdy, o_d_rdy}, 0);
        end

        // both saturated: last owner was I, so D goes first, then strict alternation
        tick();
        i_re = 1'b1; i_addr = 32'h0040_0000;
        d_re = 1'b1; d_addr = 32'h1001_0004;
        n_rdy = 0; prev_p = -1; last_seen[0] = -1; last_seen[1] = -1;
        for (int c = 0; c < 22; c++) begin
            if (c > 0) tick();
            @(negedge clk);
            if (c == 2) check("sat first is D", o_d_rdy, 1);
            if (c >= 2 && (o_i_rdy || o_d_rdy)) begin
                n_rdy++;
                check("sat single ready", o_i_rdy & o_d_rdy, 0);
                cur_p = o_d_rdy ? 1 : 0;
                if (prev_p >= 0) check("sat alternate", cur_p, 1 - prev_p);
                if (last_seen[cur_p] >= 0) check("sat wait<=4", (c - last_seen[cur_p]) <= 4, 1);
                last_seen[cur_p] = c;
                prev_p = cur_p;
            end
        end
        check("sat ready count", n_rdy, 10);
        i_seen = 1'b0; d_seen = 1'b0;
        for (int k = 0; k < 12 && (i_re || d_re); k++) begin
            tick();
            if (i_seen) i_re = 1'b0;
            if (d_seen) d_re = 1'b0;
            @(negedge clk);
            i_seen = o_i_rdy; d_seen = o_d_rdy;
        end
        check("sat drained", {i_re, d_re}, 0);

        // reset during ISSUE of a data write
        tick();
        d_we = 1'b1; d_addr = 32'h1001_0010; d_wdata = 32'hFFFF_FFFF; d_be = 4'hF;
        @(negedge clk);
        tick(); #1;
        check("rstmid pre mwe", o_m_we, 1);
        rst_n = 1'b0;
        #1;
        check("rstmid mwe async", o_m_we, 0);
        check("rstmid outs zero", {o_i_rdy, o_d_rdy, o_m_re, o_m_be, o_m_addr, o_m_wdata}, 0);
        check("rstmid rdata zero", {o_i_rdata, o_d_rdata}, 0);
        d_we = 1'b0;
        @(negedge clk);
        check("rstmid no drdy a", o_d_rdy, 0);
        tick(); @(negedge clk);
        check("rstmid no drdy b", o_d_rdy, 0);
        tick(); rst_n = 1'b1;
        tick(); i_re = 1'b1; i_addr = 32'h1001_0010; @(negedge clk);
        tick(); @(negedge clk);
        check("rstmid i mre", o_m_re, 1);
        tick(); @(negedge clk);
        check("rstmid i rdy", o_i_rdy, 1);
        check("rstmid i data", o_i_rdata, 32'hC0DE_0004);
        tick(); i_re = 1'b0;

        // randomized traffic against a transaction-level model
        rst_n = 1'b0;
        @(negedge clk);
        tick(); rst_n = 1'b1;
        for (int k = 0; k < 64; k++) ref_mem[k] = init_word(k);
        have_txn = 1'b0; have_hist = 1'b0; last_d = 1'b0; g_cyc = 0;
        g_d = 1'b0; g_wr = 1'b0; g_addr = '0; g_wdata = '0; g_rdata = '0; g_be = '0;
        hold_i = '0; hold_d = '0; i_seen = 1'b0; d_seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (i_seen) i_re = 1'b0;
            if (d_seen) begin d_re = 1'b0; d_we = 1'b0; end
            if (!i_re && $urandom_range(0, 2) != 0) begin
                i_re = 1'b1; i_addr = rand_addr();
            end
            if (!d_re && !d_we && $urandom_range(0, 2) != 0) begin
                r = $urandom_range(0, 3);
                d_re = (r != 1); d_we = (r == 1 || r == 2);
                d_addr = rand_addr(); d_wdata = $urandom; d_be = 4'($urandom_range(1, 15));
            end
            @(negedge clk);

            exp_ir = have_txn && (c == g_cyc + 2) && !g_d;
            exp_dr = have_txn && (c == g_cyc + 2) && g_d;
            check("rnd irdy", o_i_rdy, exp_ir);
            check("rnd drdy", o_d_rdy, exp_dr);
            check("rnd mre", o_m_re, have_txn && (c == g_cyc + 1) && !g_wr);
            check("rnd mwe", o_m_we, have_txn && (c == g_cyc + 1) && g_wr);
            if (have_txn && c == g_cyc + 1) begin
                check("rnd maddr", o_m_addr, g_addr);
                check("rnd mbe", o_m_be, g_be);
                if (g_wr) check("rnd mwdata", o_m_wdata, g_wdata);
            end
            check("rnd idata", o_i_rdata, exp_ir ? g_rdata : hold_i);
            check("rnd ddata", o_d_rdata, (exp_dr && !g_wr) ? g_rdata : hold_d);
            if (exp_ir) hold_i = g_rdata;
            if (exp_dr && !g_wr) hold_d = g_rdata;

            can_i = i_re; can_d = d_re | d_we;
            if (have_txn && c < g_cyc + 2) begin
                can_i = 1'b0; can_d = 1'b0;
            end else if (have_txn && c == g_cyc + 2) begin
                if (g_d) can_d = 1'b0;
                else     can_i = 1'b0;
            end
            if (can_i || can_d) begin
                if (can_i && can_d) win_d = have_hist ? !last_d : D_FIRST_TB;
                else                win_d = can_d;
                have_hist = 1'b1; last_d = win_d; have_txn = 1'b1;
                g_cyc = c; g_d = win_d;
                if (win_d) begin
                    g_wr = d_we; g_addr = d_addr; g_wdata = d_wdata;
                    g_be = d_we ? d_be : 4'hF;
                end else begin
                    g_wr = 1'b0; g_addr = i_addr; g_be = 4'hF;
                end
                if (g_wr) begin
                    for (int b = 0; b < 4; b++)
                        if (g_be[b]) ref_mem[g_addr[7:2]][8*b +: 8] = g_wdata[8*b +: 8];
                end else begin
                    g_rdata = ref_mem[g_addr[7:2]];
                end
            end
            i_seen = o_i_rdy; d_seen = o_d_rdy;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
